// File: rtl/flaf_trial_sequencer_if.sv
// Signal bundle between the trial sequencer and its environment:
// run control, sample memory, filter under test, capture port and run status.
interface flaf_trial_sequencer_if #(
    parameter int WIDTH   = 16,
    parameter int AW      = 15,
    parameter int LAT_W   = 4,
    parameter int TRIAL_W = 8,
    parameter int ACC_W   = 48
);
    logic                start;
    logic                abort;
    logic [AW:0]         cfg_n;
    logic [TRIAL_W-1:0]  cfg_trials;
    logic [LAT_W-1:0]    cfg_lat;
    logic                mem_rd;
    logic [AW-1:0]       mem_addr;
    logic [TRIAL_W-1:0]  mem_trial;
    logic [WIDTH-1:0]    mem_x;
    logic [WIDTH-1:0]    mem_d;
    logic                flt_reset;
    logic                flt_valid;
    logic [WIDTH-1:0]    flt_x;
    logic [WIDTH-1:0]    flt_d;
    logic [WIDTH-1:0]    flt_error;
    logic                cap_we;
    logic [AW-1:0]       cap_addr;
    logic [WIDTH-1:0]    cap_data;
    logic [ACC_W-1:0]    sse;
    logic                sse_valid;
    logic [TRIAL_W-1:0]  trial_idx;
    logic                busy;
    logic                done;

    // The sequencer is the master; memory, filter and host form the slave side.
    modport master (
        input  start, abort, cfg_n, cfg_trials, cfg_lat, mem_x, mem_d, flt_error,
        output mem_rd, mem_addr, mem_trial, flt_reset, flt_valid, flt_x, flt_d,
               cap_we, cap_addr, cap_data, sse, sse_valid, trial_idx, busy, done
    );

    modport slave (
        output start, abort, cfg_n, cfg_trials, cfg_lat, mem_x, mem_d, flt_error,
        input  mem_rd, mem_addr, mem_trial, flt_reset, flt_valid, flt_x, flt_d,
               cap_we, cap_addr, cap_data, sse, sse_valid, trial_idx, busy, done
    );
endinterface

// File: rtl/flaf_trial_sequencer.sv
// Multi-trial stimulus/capture engine for functional-link adaptive filters:
// streams x/d samples, resets the filter between trials, captures aligned error and its SSE.
module flaf_trial_sequencer #(
    parameter int WIDTH   = 16,
    parameter int AW      = 15,
    parameter int LAT_W   = 4,
    parameter int TRIAL_W = 8,
    parameter int ACC_W   = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    flaf_trial_sequencer_if.master  bus
);
    localparam int CW    = AW + 2;
    localparam int SQ_W  = 2 * WIDTH;
    localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam logic [AW:0]       N_MIN   = (AW+1)'(2);
    localparam logic [AW:0]       N_MAX   = {1'b1, {AW{1'b0}}};
    localparam logic [ACC_W-1:0]  ACC_MAX = '1;

    typedef enum logic [2:0] {IDLE, FRST, PREF, STREAM, FLUSH, REPORT, DONE} state_t;

    state_t              r_state;
    logic [AW:0]         r_n;
    logic [TRIAL_W-1:0]  r_trials;
    logic [TRIAL_W-1:0]  r_trialIdx;
    logic [LAT_W-1:0]    r_lat;
    logic                r_frstCnt;
    logic [CW-1:0]       r_c;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_sse;
    logic                r_memRd;
    logic [AW-1:0]       r_memAddr;
    logic                r_fltReset;
    logic                r_fltValid;
    logic [WIDTH-1:0]    r_fltX;
    logic [WIDTH-1:0]    r_fltD;
    logic                r_capWe;
    logic [AW-1:0]       r_capAddr;
    logic                r_sseValid;
    logic                r_busy;
    logic                r_done;

    logic [AW:0]              w_nClamp;
    logic [CW-1:0]            w_cNext;
    logic [CW-1:0]            w_nExt;
    logic [CW-1:0]            w_latExt;
    logic [CW-1:0]            w_last;
    logic [TRIAL_W:0]         w_trialNext;
    logic signed [SQ_W-1:0]   w_errExt;
    logic signed [SQ_W-1:0]   w_sq;
    logic [SUM_W-1:0]         w_sum;
    logic [ACC_W-1:0]         w_accNext;

    assign w_nClamp    = (bus.cfg_n < N_MIN) ? N_MIN : ((bus.cfg_n > N_MAX) ? N_MAX : bus.cfg_n);
    assign w_cNext     = r_c + CW'(1);
    assign w_nExt      = CW'(r_n);
    assign w_latExt    = CW'(r_lat);
    assign w_last      = w_nExt + w_latExt - CW'(1);
    assign w_trialNext = {1'b0, r_trialIdx} + (TRIAL_W+1)'(1);

    // Squared error is non-negative, so the sum is taken unsigned and clamped rather than wrapped.
    assign w_errExt  = SQ_W'($signed(bus.flt_error));
    assign w_sq      = w_errExt * w_errExt;
    assign w_sum     = SUM_W'(r_acc) + SUM_W'($unsigned(w_sq));
    assign w_accNext = (w_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : w_sum[ACC_W-1:0];

    // Counter r_c is the stream/flush cycle index; every output is set one edge ahead of its cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_trials   <= '0;
            r_trialIdx <= '0;
            r_lat      <= '0;
            r_frstCnt  <= 1'b0;
            r_c        <= '0;
            r_acc      <= '0;
            r_sse      <= '0;
            r_memRd    <= 1'b0;
            r_memAddr  <= '0;
            r_fltReset <= 1'b1;
            r_fltValid <= 1'b0;
            r_fltX     <= '0;
            r_fltD     <= '0;
            r_capWe    <= 1'b0;
            r_capAddr  <= '0;
            r_sseValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sseValid <= 1'b0;
            r_done     <= 1'b0;
            if (bus.abort) begin
                r_state    <= IDLE;
                r_fltReset <= 1'b1;
                r_fltValid <= 1'b0;
                r_capWe    <= 1'b0;
                r_memRd    <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_n        <= w_nClamp;
                            r_trials   <= (bus.cfg_trials == '0) ? TRIAL_W'(1) : bus.cfg_trials;
                            r_lat      <= bus.cfg_lat;
                            r_trialIdx <= '0;
                            r_frstCnt  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= FRST;
                        end
                    end
                    FRST: begin
                        r_acc <= '0;
                        if (r_frstCnt) begin
                            r_state    <= PREF;
                            r_fltReset <= 1'b0;
                            r_memRd    <= 1'b1;
                            r_memAddr  <= '0;
                        end else begin
                            r_frstCnt <= 1'b1;
                        end
                    end
                    PREF: begin
                        r_fltX     <= bus.mem_x;
                        r_fltD     <= bus.mem_d;
                        r_c        <= '0;
                        r_fltValid <= 1'b1;
                        r_memRd    <= 1'b1;
                        r_memAddr  <= AW'(1);
                        r_capWe    <= (r_lat == '0);
                        r_capAddr  <= '0;
                        r_state    <= STREAM;
                    end
                    STREAM, FLUSH: begin
                        if (r_memRd) begin
                            r_fltX <= bus.mem_x;
                            r_fltD <= bus.mem_d;
                        end
                        if (r_capWe) begin
                            r_acc <= w_accNext;
                        end
                        if (r_c == w_last) begin
                            r_state    <= REPORT;
                            r_fltValid <= 1'b0;
                            r_capWe    <= 1'b0;
                            r_memRd    <= 1'b0;
                            r_sse      <= r_capWe ? w_accNext : r_acc;
                            r_sseValid <= 1'b1;
                        end else begin
                            r_c       <= w_cNext;
                            r_state   <= (w_cNext < w_nExt) ? STREAM : FLUSH;
                            r_memRd   <= ((w_cNext + CW'(1)) < w_nExt);
                            r_memAddr <= AW'(w_cNext + CW'(1));
                            r_capWe   <= (w_cNext >= w_latExt);
                            r_capAddr <= AW'(w_cNext - w_latExt);
                        end
                    end
                    REPORT: begin
                        if (w_trialNext < {1'b0, r_trials}) begin
                            r_trialIdx <= w_trialNext[TRIAL_W-1:0];
                            r_frstCnt  <= 1'b0;
                            r_fltReset <= 1'b1;
                            r_state    <= FRST;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                    DONE: begin
                        r_busy     <= 1'b0;
                        r_fltReset <= 1'b1;
                        r_state    <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_rd    = r_memRd;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_trial = r_trialIdx;
    assign bus.flt_reset = r_fltReset;
    assign bus.flt_valid = r_fltValid;
    assign bus.flt_x     = r_fltX;
    assign bus.flt_d     = r_fltD;
    assign bus.cap_we    = r_capWe;
    assign bus.cap_addr  = r_capAddr;
    assign bus.cap_data  = r_capWe ? bus.flt_error : '0;
    assign bus.sse       = r_sse;
    assign bus.sse_valid = r_sseValid;
    assign bus.trial_idx = r_trialIdx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_flaf_trial_sequencer.sv
// Self-checking bench for flaf_trial_sequencer: table of full runs against a
// sample-memory and filter model, plus hand-written abort/reset/restart sequences.
module tb_flaf_trial_sequencer;
    localparam int WIDTH   = 16;
    localparam int AW      = 15;
    localparam int LAT_W   = 4;
    localparam int TRIAL_W = 8;
    localparam int ACC_W   = 20;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam int SNAP_W  = 7 + 2*AW + 2*TRIAL_W + 3*WIDTH + ACC_W;

    typedef struct {
        int          n;
        int          trials;
        int          lat;
        int          mode;
        logic [15:0] errC;
        longint      expSse;
        int          expBusy;
        int          expValid;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   modelMode = 0;
    int   modelLat  = 0;
    logic [WIDTH-1:0] errConst = '0;
    logic [WIDTH-1:0] pipe [16];
    vec_t vecs [5];

    always #5 clk = ~clk;

    flaf_trial_sequencer_if #(.WIDTH(WIDTH), .AW(AW), .LAT_W(LAT_W), .TRIAL_W(TRIAL_W), .ACC_W(ACC_W)) bus ();

    flaf_trial_sequencer #(.WIDTH(WIDTH), .AW(AW), .LAT_W(LAT_W), .TRIAL_W(TRIAL_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Sample memory: x = k, d = 2k + trial, so the ideal filter error d - x equals k + trial.
    always_comb begin
        bus.mem_x = WIDTH'(bus.mem_addr);
        bus.mem_d = WIDTH'(2 * int'(bus.mem_addr) + int'(bus.mem_trial));
    end

    // Filter stand-in: either a modelLat-stage delay of d - x or a constant error.
    always @(posedge clk) begin
        pipe[0] <= bus.flt_d - bus.flt_x;
        for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        if (modelMode == 1)      bus.flt_error = errConst;
        else if (modelLat == 0)  bus.flt_error = bus.flt_d - bus.flt_x;
        else                     bus.flt_error = pipe[modelLat-1];
    end

    function automatic logic [SNAP_W-1:0] snapshot();
        return {bus.flt_reset, bus.busy, bus.done, bus.mem_rd, bus.flt_valid, bus.cap_we,
                bus.sse_valid, bus.mem_addr, bus.mem_trial, bus.flt_x, bus.flt_d,
                bus.cap_addr, bus.cap_data, bus.sse, bus.trial_idx};
    endfunction

    function automatic longint modelSse(int mode, int n, int t, logic [15:0] c);
        longint s = 0;
        longint e;
        for (int k = 0; k < n; k++) begin
            e = (mode == 1) ? longint'($signed(c)) : longint'(k + t);
            s += e * e;
        end
        return (s > ACC_MAX) ? ACC_MAX : s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic startRun(input vec_t v);
        modelMode = v.mode;
        modelLat  = v.lat;
        errConst  = v.errC;
        @(negedge clk);
        bus.cfg_n      = (AW+1)'(v.n);
        bus.cfg_trials = TRIAL_W'(v.trials);
        bus.cfg_lat    = LAT_W'(v.lat);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    // Full run with per-cycle checks; injectAt >= 0 pulses a conflicting start mid-run.
    task automatic applyStimulus(input vec_t v, input int injectAt, input string tag);
        int nEff, trEff, t, vcnt, capCount, busyCycles, validCycles, rstCycles, sseCount, xs;
        bit seenDone;
        nEff  = (v.n < 2) ? 2 : ((v.n > (1 << AW)) ? (1 << AW) : v.n);
        trEff = (v.trials == 0) ? 1 : v.trials;
        t = 0; vcnt = 0; capCount = 0; busyCycles = 0; validCycles = 0; rstCycles = 0; sseCount = 0;
        seenDone = 1'b0;
        startRun(v);
        for (int cyc = 0; cyc < 4000 && !seenDone; cyc++) begin
            if (bus.busy && !bus.done) busyCycles++;
            if (bus.busy && bus.flt_reset) rstCycles++;
            if (bus.flt_valid) begin
                xs = (vcnt < nEff) ? vcnt : nEff - 1;
                checkOutput({tag, "_flt_xd"}, {bus.flt_x, bus.flt_d},
                            {WIDTH'(xs), WIDTH'(2 * xs + t)});
                vcnt++;
                validCycles++;
            end
            if (bus.cap_we) begin
                checkOutput({tag, "_cap_addr"}, bus.cap_addr, capCount);
                checkOutput({tag, "_cap_data"}, bus.cap_data,
                            (v.mode == 1) ? v.errC : WIDTH'(capCount + t));
                capCount++;
            end
            if (bus.sse_valid) begin
                checkOutput({tag, "_sse_trial"}, bus.sse, modelSse(v.mode, nEff, t, v.errC));
                checkOutput({tag, "_captures"}, capCount, nEff);
                checkOutput({tag, "_trial_idx"}, bus.trial_idx, t);
                capCount = 0;
                vcnt = 0;
                t++;
                sseCount++;
            end
            if (bus.done) begin
                seenDone = 1'b1;
                checkOutput({tag, "_final_sse"}, bus.sse, v.expSse);
                checkOutput({tag, "_final_trial_idx"}, bus.trial_idx, trEff - 1);
            end
            if (cyc == injectAt) begin
                bus.cfg_n      = (AW+1)'(4);
                bus.cfg_lat    = '0;
                bus.cfg_trials = TRIAL_W'(2);
                bus.start      = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, seenDone, 1'b1);
        checkOutput({tag, "_busy_cycles"}, busyCycles, v.expBusy);
        checkOutput({tag, "_valid_cycles"}, validCycles, v.expValid);
        checkOutput({tag, "_flt_reset_cycles"}, rstCycles, 2 * trEff);
        checkOutput({tag, "_sse_pulses"}, sseCount, trEff);
        checkOutput({tag, "_idle_after"}, {bus.busy, bus.done, bus.flt_reset}, 3'b001);
    endtask

    initial begin
        automatic int vc;
        automatic int quiet;
        automatic longint lastSse;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_n = '0;
        bus.cfg_trials = '0;
        bus.cfg_lat = '0;
        reset = 1'b0;

        vecs[0] = '{8,  1, 5, 0, 16'h0000, 140,     17, 13};
        vecs[1] = '{4,  1, 0, 1, 16'h0003, 36,      8,  4};
        vecs[2] = '{16, 3, 2, 0, 16'h0000, 1784,    66, 54};
        vecs[3] = '{64, 1, 1, 1, 16'h8000, 1048575, 69, 65};
        vecs[4] = '{1,  0, 3, 0, 16'h0000, 1,       9,  5};

        repeat (3) @(negedge clk);
        checkOutput("reset_values", snapshot(), {1'b1, (SNAP_W-1)'(0)});
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d: n=%0d trials=%0d lat=%0d", i, vecs[i].n, vecs[i].trials, vecs[i].lat);
            applyStimulus(vecs[i], -1, $sformatf("vec%0d", i));
        end
        lastSse = vecs[4].expSse;

        // start pulsed in stream cycle 3 with different cfg must change nothing
        applyStimulus(vecs[0], 6, "start_busy");
        lastSse = vecs[0].expSse;

        // abort in stream cycle 3
        startRun(vecs[2]);
        vc = 0;
        for (int i = 0; i < 50 && vc < 4; i++) begin
            @(negedge clk);
            if (bus.flt_valid) vc++;
        end
        checkOutput("abort_reach_stream3", vc, 4);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort_next_cycle", {bus.flt_reset, bus.flt_valid, bus.cap_we, bus.mem_rd, bus.busy}, 5'b10000);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.cap_we || bus.done || bus.sse_valid || bus.busy) quiet++;
            @(negedge clk);
        end
        checkOutput("abort_quiet", quiet, 0);
        checkOutput("abort_sse_kept", bus.sse, lastSse);
        applyStimulus(vecs[0], -1, "after_abort");

        // abort and start together in IDLE: abort wins
        bus.cfg_n = (AW+1)'(8);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput("abort_beats_start", {bus.busy, bus.flt_reset}, 2'b01);
        @(negedge clk);
        checkOutput("abort_beats_start_later", bus.busy, 1'b0);

        // asynchronous reset in FLUSH cycle 2
        startRun(vecs[0]);
        vc = 0;
        for (int i = 0; i < 50 && vc < 10; i++) begin
            @(negedge clk);
            if (bus.flt_valid) vc++;
        end
        checkOutput("reset_reach_flush", vc, 10);
        #1 reset = 1'b0;
        #1 checkOutput("reset_mid_flush", snapshot(), {1'b1, (SNAP_W-1)'(0)});
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(vecs[1], -1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/flaf_trial_sequencer.md
Name: flaf_trial_sequencer

Overview:
- Synthesizable stimulus/capture engine for the functional-link adaptive filter cores (TFLAF and variants).
- Streams x/d samples from an external sample memory into the filter over a configurable number of trials, and resets the filter between trials.
- Discards the first cfg_lat filter outputs (retiming latency), writes each aligned error sample to a capture port, and reports the per-trial sum of squared error.
- Replaces file-driven bench sequencing so long multi-trial runs execute on-chip or on FPGA.

Parameters:
WIDTH, 16, sample / error word width (two's complement)
AW, 15, sample address width; max samples per trial 2^AW
LAT_W, 4, width of cfg_lat (max filter latency 2^LAT_W-1)
TRIAL_W, 8, width of trial counter
ACC_W, 48, SSE accumulator width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches cfg_* and begins a run (ignored while busy)
abort  input  1  terminates the run; sequencer returns to IDLE next cycle
cfg_n  input  AW+1  samples per trial, 2..2^AW
cfg_trials  input  TRIAL_W  number of trials, 1..2^TRIAL_W-1 (0 treated as 1)
cfg_lat  input  LAT_W  filter input-to-error latency in cycles
mem_rd  output  1  sample memory read enable
mem_addr  output  AW  sample index
mem_trial  output  TRIAL_W  trial index for memory bank select
mem_x  input  WIDTH  x sample; valid 1 cycle after mem_rd
mem_d  input  WIDTH  d sample; valid 1 cycle after mem_rd
flt_reset  output  1  active-high filter reset
flt_valid  output  1  filter ip_valid
flt_x  output  WIDTH  filter signal_in (registered)
flt_d  output  WIDTH  filter desired_in (registered)
flt_error  input  WIDTH  filter error output
cap_we  output  1  capture write strobe
cap_addr  output  AW  capture index 0..cfg_n-1
cap_data  output  WIDTH  captured error
sse  output  ACC_W  sum of squared error of the last completed trial
sse_valid  output  1  one-cycle pulse when sse updates
trial_idx  output  TRIAL_W  current trial, 0-based
busy  output  1  high from accepted start until DONE
done  output  1  one-cycle pulse at end of the run

Behaviour:
- Reset values: all outputs 0 except flt_reset=1. FSM=IDLE; counters and accumulator cleared.
- States: IDLE, FRST, PREF, STREAM, FLUSH, REPORT, DONE.
- IDLE: flt_reset=1. On start, latch cfg_* and go to FRST.
- FRST: flt_reset=1 for exactly 2 cycles; SSE accumulator cleared; go to PREF.
- PREF (1 cycle): flt_reset=0, mem_rd=1, mem_addr=0; go to STREAM.
- STREAM: in stream cycle j (j=0..cfg_n-1), flt_x/flt_d hold sample j and flt_valid=1. mem_rd/mem_addr run one sample ahead; mem_rd is low in the last cycle. After cycle cfg_n-1, go to FLUSH.
- FLUSH: lasts cfg_lat cycles. flt_valid stays 1 and the last sample is held on flt_x/flt_d. If cfg_lat=0, FLUSH is skipped.
- Capture: a cycle counter c starts at 0 in stream cycle 0 and runs through STREAM and FLUSH. For c >= cfg_lat:
  - cap_we=1, cap_addr=c-cfg_lat, cap_data=flt_error.
  - The accumulator adds flt_error*flt_error (signed 2*WIDTH product, zero-extended) and saturates at 2^ACC_W-1.
  - Exactly cfg_n captures occur per trial.
- REPORT (1 cycle): sse is registered from the accumulator and sse_valid is pulsed. If trial_idx+1 < cfg_trials, increment trial_idx and go to FRST; otherwise go to DONE.
- DONE (1 cycle): done=1; go to IDLE. busy drops with the DONE→IDLE transition. trial_idx holds its value until the next start.
- Cycles per trial: 2 + 1 + cfg_n + cfg_lat + 1.
- start while busy: ignored, and cfg_* are not re-latched.
- abort (any non-IDLE state): next cycle FSM=IDLE, flt_reset=1, flt_valid=0, cap_we=0, mem_rd=0. No sse_valid or done pulse; sse keeps its previous value.
- abort together with start in IDLE: abort wins and start is dropped.
- Asynchronous reset mid-run: immediate return to reset values; the partial trial is discarded.
- cfg_n outside 2..2^AW is clamped to that range.

Test Plan:
- Basic run: cfg_n=8, cfg_lat=5, cfg_trials=1; memory x=k, d=2k; filter model = 5-stage delay of d-x → cap_addr 0..7 gets data 0..7 in order, sse=140, exactly one sse_valid, done pulse 17 cycles after start.
- Latency zero: cfg_lat=0, cfg_n=4, error stuck at 16'h0003 → 4 captures starting in stream cycle 0, sse=36, FLUSH not entered.
- Multi-trial: cfg_trials=3, cfg_n=16 → flt_reset high 2 cycles before each trial, mem_trial steps 0,1,2, three sse_valid pulses, one done.
- Saturation: ACC_W=20, error=16'h8000, cfg_n=64 → sse=20'hFFFFF, no wrap.
- Abort: abort in stream cycle 3 → next cycle flt_reset=1, no further cap_we, no done; a fresh start then completes normally.
- Reset and start while busy: reset asserted mid-FLUSH → all outputs at reset values immediately. A separate run: start pulsed during STREAM → ignored, cfg unchanged, cycle count unaffected.
